wb_write_arbiter: RTL and testbench

Writeback-side producer for the dual-write-port `register_file`. It accepts destination/result pairs from two pipeline result channels (A: ALU, B: load/MEM) over valid/ready handshakes and buffers them in a small in-order queue. It drains up to two entries per cycle onto the register file's `write_addr`/`data`/`WE` and `write_addr2`/`data2`/`WE2` ports. It drops writes to `$0`, merges same-cycle same-destination writes, and exports a pending-write mask for hazard stall logic.

---
 rtl/wb_write_arbiter.sv | 145 ++++++++++++++
 tb/tb_wb_write_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_write_arbiter.sv
// Writeback arbiter: merges ALU and load result channels into an in-order queue
// and drains up to two writes per cycle into the dual-port register file.
// Optional store-to-read forwarding lookup is enabled with `define WB_FWD_EN.
module wb_write_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [4:0]  a_addr,
  input  logic [31:0] a_data,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [4:0]  b_addr,
  input  logic [31:0] b_data,
  output logic [4:0]  write_addr,
  output logic [31:0] data,
  output logic        WE,
  output logic [4:0]  write_addr2,
  output logic [31:0] data2,
  output logic        WE2,
  output logic [31:0] busy_mask,
`ifdef WB_FWD_EN
  input  logic [4:0]  fwd_addr,
  output logic        fwd_hit,
  output logic [31:0] fwd_data,
`endif
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = PW + 1;

  logic [4:0]    addr_mem [DEPTH];
  logic [31:0]   data_mem [DEPTH];
  logic [PW-1:0] head_q;
  logic [PW-1:0] tail_q;
  logic [OW-1:0] occ_q;

  logic          ready;
  logic          a_fire;
  logic          b_fire;
  logic [1:0]    enq_cnt;
  logic [1:0]    drain_cnt;
  logic [PW-1:0] head_p1;
  logic [PW-1:0] b_slot;
  logic [31:0]   busy_raw;

  // Drain never leaves more than DEPTH-2 behind, so two slots are always free.
  assign ready   = rst_n && (occ_q <= OW'(DEPTH - 2));
  assign a_ready = ready;
  assign b_ready = ready;

  assign a_fire  = a_valid && ready && (a_addr != 5'd0);
  assign b_fire  = b_valid && ready && (b_addr != 5'd0);
  assign enq_cnt = {1'b0, a_fire} + {1'b0, b_fire};

  assign head_p1 = head_q + PW'(1);
  assign b_slot  = a_fire ? (tail_q + PW'(1)) : tail_q;

  always_comb begin
    drain_cnt = 2'd0;
    if (occ_q >= OW'(2))
      drain_cnt = 2'd2;
    else if (occ_q == OW'(1))
      drain_cnt = 2'd1;
  end

  always_comb begin
    WE          = 1'b0;
    write_addr  = 5'd0;
    data        = 32'd0;
    WE2         = 1'b0;
    write_addr2 = 5'd0;
    data2       = 32'd0;
    if (rst_n && drain_cnt == 2'd2) begin
      WE2         = 1'b1;
      write_addr2 = addr_mem[head_p1];
      data2       = data_mem[head_p1];
      // Same destination: the older value would be overwritten anyway.
      if (addr_mem[head_q] != addr_mem[head_p1]) begin
        WE         = 1'b1;
        write_addr = addr_mem[head_q];
        data       = data_mem[head_q];
      end
    end else if (rst_n && drain_cnt == 2'd1) begin
      WE         = 1'b1;
      write_addr = addr_mem[head_q];
      data       = data_mem[head_q];
    end
  end

  always_comb begin
    busy_raw = 32'd0;
    for (int k = 0; k < DEPTH; k++) begin
      if (OW'(k) < occ_q)
        busy_raw[addr_mem[head_q + PW'(k)]] = 1'b1;
    end
  end

  assign busy_mask = rst_n ? busy_raw : 32'd0;
  assign occupancy = rst_n ? occ_q : '0;

`ifdef WB_FWD_EN
  // Later matches override earlier ones, so the youngest entry wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = 32'd0;
    if (fwd_addr != 5'd0) begin
      for (int k = 0; k < DEPTH; k++) begin
        if ((OW'(k) < occ_q) && (addr_mem[head_q + PW'(k)] == fwd_addr)) begin
          fwd_hit  = 1'b1;
          fwd_data = data_mem[head_q + PW'(k)];
        end
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      head_q <= head_q + PW'(drain_cnt);
      tail_q <= tail_q + PW'(enq_cnt);
      occ_q  <= occ_q - OW'(drain_cnt) + OW'(enq_cnt);
    end
  end

  // Payload storage needs no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (a_fire) begin
      addr_mem[tail_q] <= a_addr;
      data_mem[tail_q] <= a_data;
    end
    if (b_fire) begin
      addr_mem[b_slot] <= b_addr;
      data_mem[b_slot] <= b_data;
    end
  end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed self-checking bench for wb_write_arbiter; a monitor mirrors the
// register file and logs every committed write in port order.
module tb_wb_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_valid, b_valid;
  logic        a_ready, b_ready;
  logic [4:0]  a_addr, b_addr;
  logic [31:0] a_data, b_data;
  logic [4:0]  write_addr, write_addr2;
  logic [31:0] data, data2;
  logic        WE, WE2;
  logic [31:0] busy_mask;
  logic [2:0]  occupancy;
`ifdef WB_FWD_EN
  logic [4:0]  fwd_addr;
  logic        fwd_hit;
  logic [31:0] fwd_data;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] rf [32];
  logic [36:0] wlog [$];

  always #5 clk = ~clk;

  wb_write_arbiter #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .write_addr(write_addr), .data(data), .WE(WE),
    .write_addr2(write_addr2), .data2(data2), .WE2(WE2),
    .busy_mask(busy_mask),
`ifdef WB_FWD_EN
    .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
`endif
    .occupancy(occupancy)
  );

  // Port 2 is applied after port 1, matching the register file's priority.
  always @(posedge clk) begin
    if (WE) begin
      rf[write_addr] = data;
      wlog.push_back({write_addr, data});
    end
    if (WE2) begin
      rf[write_addr2] = data2;
      wlog.push_back({write_addr2, data2});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_valid = 1'b0; a_addr = 5'd0; a_data = 32'd0;
    b_valid = 1'b0; b_addr = 5'd0; b_data = 32'd0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    step();
    n_checks++;
    if (WE !== 1'b0 || WE2 !== 1'b0) begin
      n_fail++; $display("FAIL reset_we: WE=%b WE2=%b expected 0 0", WE, WE2);
    end
    n_checks++;
    if (busy_mask !== 32'd0 || occupancy !== 3'd0) begin
      n_fail++; $display("FAIL reset_state: busy=%h occ=%0d expected 0 0", busy_mask, occupancy);
    end
    n_checks++;
    if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready: a=%b b=%b expected 0 0", a_ready, b_ready);
    end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (a_ready !== 1'b1 || b_ready !== 1'b1) begin
      n_fail++; $display("FAIL release_ready: a=%b b=%b expected 1 1", a_ready, b_ready);
    end
  endtask

  task automatic test_single();
    a_valid = 1'b1; a_addr = 5'd5; a_data = 32'hDEADBEEF;
    step();
    idle_inputs();
    n_checks++;
    if (WE !== 1'b1 || write_addr !== 5'd5 || data !== 32'hDEADBEEF || WE2 !== 1'b0) begin
      n_fail++;
      $display("FAIL single_port1: WE=%b addr=%0d data=%h WE2=%b expected 1 5 deadbeef 0",
               WE, write_addr, data, WE2);
    end
    n_checks++;
    if (busy_mask !== 32'h20 || occupancy !== 3'd1) begin
      n_fail++; $display("FAIL single_busy: busy=%h occ=%0d expected 20 1", busy_mask, occupancy);
    end
    step();
    n_checks++;
    if (WE !== 1'b0 || busy_mask !== 32'd0 || write_addr !== 5'd0) begin
      n_fail++; $display("FAIL single_drained: WE=%b busy=%h addr=%0d expected 0 0 0", WE, busy_mask, write_addr);
    end
    n_checks++;
    if (rf[5] !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL single_rf: r5=%h expected deadbeef", rf[5]);
    end
  endtask

  task automatic test_zero_discard();
    a_valid = 1'b1; a_addr = 5'd0; a_data = 32'h1111;
    b_valid = 1'b1; b_addr = 5'd0; b_data = 32'h2222;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (a_ready !== 1'b1 || b_ready !== 1'b1) begin
        n_fail++; $display("FAIL zero_ready: cyc=%0d a=%b b=%b expected 1 1", i, a_ready, b_ready);
      end
      step();
      n_checks++;
      if (WE !== 1'b0 || WE2 !== 1'b0 || occupancy !== 3'd0) begin
        n_fail++; $display("FAIL zero_drop: cyc=%0d WE=%b WE2=%b occ=%0d expected 0 0 0", i, WE, WE2, occupancy);
      end
    end
    idle_inputs();
  endtask

  task automatic test_dual();
    a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h33;
    b_valid = 1'b1; b_addr = 5'd4; b_data = 32'h44;
    step();
    idle_inputs();
    n_checks++;
    if (WE !== 1'b1 || write_addr !== 5'd3 || data !== 32'h33) begin
      n_fail++; $display("FAIL dual_port1: WE=%b addr=%0d data=%h expected 1 3 33", WE, write_addr, data);
    end
    n_checks++;
    if (WE2 !== 1'b1 || write_addr2 !== 5'd4 || data2 !== 32'h44) begin
      n_fail++; $display("FAIL dual_port2: WE2=%b addr=%0d data=%h expected 1 4 44", WE2, write_addr2, data2);
    end
    n_checks++;
    if (busy_mask !== 32'h18 || occupancy !== 3'd2) begin
      n_fail++; $display("FAIL dual_busy: busy=%h occ=%0d expected 18 2", busy_mask, occupancy);
    end
    step();
  endtask

  task automatic test_merge();
    a_valid = 1'b1; a_addr = 5'd7; a_data = 32'd1;
    b_valid = 1'b1; b_addr = 5'd7; b_data = 32'd2;
    step();
    idle_inputs();
    n_checks++;
    if (WE !== 1'b0 || write_addr !== 5'd0 || data !== 32'd0) begin
      n_fail++; $display("FAIL merge_port1: WE=%b addr=%0d data=%h expected 0 0 0", WE, write_addr, data);
    end
    n_checks++;
    if (WE2 !== 1'b1 || write_addr2 !== 5'd7 || data2 !== 32'd2) begin
      n_fail++; $display("FAIL merge_port2: WE2=%b addr=%0d data=%h expected 1 7 2", WE2, write_addr2, data2);
    end
    n_checks++;
    if (busy_mask !== 32'h80) begin
      n_fail++; $display("FAIL merge_busy: busy=%h expected 80", busy_mask);
    end
    step();
    step();
    n_checks++;
    if (rf[7] !== 32'd2) begin
      n_fail++; $display("FAIL merge_rf: r7=%h expected 2", rf[7]);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  ea;
    logic [31:0] ed;
    wlog.delete();
    for (int i = 0; i < 10; i++) begin
      a_valid = 1'b1; a_addr = 5'(2*i + 1); a_data = 32'hA000 + 32'(2*i + 1);
      b_valid = 1'b1; b_addr = 5'(2*i + 2); b_data = 32'hA000 + 32'(2*i + 2);
      n_checks++;
      if (a_ready !== 1'b1 || b_ready !== 1'b1) begin
        n_fail++; $display("FAIL stream_ready: cyc=%0d a=%b b=%b expected 1 1", i, a_ready, b_ready);
      end
      step();
      n_checks++;
      if (occupancy !== 3'd2 || WE !== 1'b1 || WE2 !== 1'b1) begin
        n_fail++; $display("FAIL stream_rate: cyc=%0d occ=%0d WE=%b WE2=%b expected 2 1 1", i, occupancy, WE, WE2);
      end
    end
    idle_inputs();
    for (int i = 0; i < 4; i++) step();
    n_checks++;
    if (wlog.size() !== 20) begin
      n_fail++; $display("FAIL stream_count: writes=%0d expected 20", wlog.size());
    end
    for (int i = 0; i < 20 && i < wlog.size(); i++) begin
      ea = 5'(i + 1);
      ed = 32'hA000 + 32'(i + 1);
      n_checks++;
      if (wlog[i] !== {ea, ed}) begin
        n_fail++; $display("FAIL stream_order: idx=%0d got=%h expected=%h", i, wlog[i], {ea, ed});
      end
    end
  endtask

  task automatic test_wrap_single();
    // A-only then B-only at occupancy 1 walks the pointers by one slot per cycle.
    wlog.delete();
    for (int i = 0; i < 6; i++) begin
      a_valid = (i % 2 == 0); a_addr = 5'(21 + i); a_data = 32'hB000 + 32'(i);
      b_valid = (i % 2 == 1); b_addr = 5'(21 + i); b_data = 32'hB000 + 32'(i);
      step();
      n_checks++;
      if (occupancy !== 3'd1 || WE !== 1'b1 || write_addr !== 5'(21 + i) || WE2 !== 1'b0) begin
        n_fail++;
        $display("FAIL wrap_single: cyc=%0d occ=%0d WE=%b addr=%0d WE2=%b expected 1 1 %0d 0",
                 i, occupancy, WE, write_addr, WE2, 21 + i);
      end
    end
    idle_inputs();
    step();
    n_checks++;
    if (wlog.size() !== 6) begin
      n_fail++; $display("FAIL wrap_count: writes=%0d expected 6", wlog.size());
    end
  endtask

  task automatic test_reset_mid();
    wlog.delete();
    a_valid = 1'b1; a_addr = 5'd10; a_data = 32'hC0;
    b_valid = 1'b1; b_addr = 5'd11; b_data = 32'hC1;
    step();
    a_addr = 5'd12; a_data = 32'hC2;
    b_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (WE !== 1'b0 || WE2 !== 1'b0 || a_ready !== 1'b0) begin
      n_fail++; $display("FAIL midreset_gate: WE=%b WE2=%b a_ready=%b expected 0 0 0", WE, WE2, a_ready);
    end
    step();
    idle_inputs();
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (WE !== 1'b0 || WE2 !== 1'b0 || occupancy !== 3'd0 || busy_mask !== 32'd0) begin
      n_fail++;
      $display("FAIL midreset_state: WE=%b WE2=%b occ=%0d busy=%h expected 0 0 0 0", WE, WE2, occupancy, busy_mask);
    end
    for (int i = 0; i < 3; i++) step();
    n_checks++;
    if (wlog.size() !== 0) begin
      n_fail++; $display("FAIL midreset_lost: writes=%0d expected 0", wlog.size());
    end
  endtask

`ifdef WB_FWD_EN
  task automatic test_fwd();
    fwd_addr = 5'd9;
    a_valid = 1'b1; a_addr = 5'd9; a_data = 32'h11;
    b_valid = 1'b1; b_addr = 5'd9; b_data = 32'h22;
    step();
    idle_inputs();
    #1;
    n_checks++;
    if (fwd_hit !== 1'b1 || fwd_data !== 32'h22) begin
      n_fail++; $display("FAIL fwd_hit: hit=%b data=%h expected 1 22", fwd_hit, fwd_data);
    end
    fwd_addr = 5'd3;
    #1;
    n_checks++;
    if (fwd_hit !== 1'b0) begin
      n_fail++; $display("FAIL fwd_miss: hit=%b expected 0", fwd_hit);
    end
    step();
  endtask
`endif

  initial begin
    for (int r = 0; r < 32; r++) rf[r] = 32'd0;
`ifdef WB_FWD_EN
    fwd_addr = 5'd0;
`endif
    test_reset();
    test_single();
    test_zero_discard();
    test_dual();
    test_merge();
    test_back_to_back();
    test_wrap_single();
    test_reset_mid();
`ifdef WB_FWD_EN
    test_fwd();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: sim time exceeded limit");
    $fatal(1, "timeout");
  end

endmodule
